// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encodings and the port-select constants used by the top and priority block.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data ports: data has priority unless
// fetch has lost STARVE_MAX consecutive decisions while requesting.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_decide,
  input  logic i_if_req,
  input  logic i_dm_req,
  output logic o_sel,
  output logic o_any
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          w_starved;

  always_comb begin
    w_starved = (r_starve_cnt == CW'(STARVE_MAX));
    o_any     = i_if_req | i_dm_req;
    if (i_dm_req && !(i_if_req && w_starved)) begin
      o_sel = SEL_DM;
    end else begin
      o_sel = SEL_IF;
    end
  end

  // Count only decisions where fetch was waiting and lost; any fetch win clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= {CW{1'b0}};
    end else if (i_decide && o_any) begin
      if (o_sel == SEL_IF) begin
        r_starve_cnt <= {CW{1'b0}};
      end else if (i_if_req && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Shares one single-port synchronous memory between the fetch port and the
// load/store port, one transaction in flight, all outputs registered.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          CLK,
  input  logic          RST_F,
  input  logic          IF_REQ,
  input  logic [AW-1:0] IF_ADDR,
  output logic          IF_GNT,
  output logic          IF_RVALID,
  output logic [DW-1:0] IF_RDATA,
  input  logic          DM_REQ,
  input  logic          DM_WE,
  input  logic [AW-1:0] DM_ADDR,
  input  logic [DW-1:0] DM_WDATA,
  output logic          DM_GNT,
  output logic          DM_RVALID,
  output logic [DW-1:0] DM_RDATA,
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          BUSY
);

  localparam int LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

  state_t           r_state;
  logic             r_sel;
  logic             r_we;
  logic [LAT_W-1:0] r_lat_cnt;
  logic             w_decide;
  logic             w_sel;
  logic             w_any;

  assign w_decide = (r_state == ST_IDLE) || (r_state == ST_DONE);

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .i_clk   (CLK),
    .i_rst_n (RST_F),
    .i_decide(w_decide),
    .i_if_req(IF_REQ),
    .i_dm_req(DM_REQ),
    .o_sel   (w_sel),
    .o_any   (w_any)
  );

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      r_state   <= ST_IDLE;
      r_sel     <= SEL_IF;
      r_we      <= 1'b0;
      r_lat_cnt <= {LAT_W{1'b0}};
      IF_GNT    <= 1'b0;
      IF_RVALID <= 1'b0;
      IF_RDATA  <= {DW{1'b0}};
      DM_GNT    <= 1'b0;
      DM_RVALID <= 1'b0;
      DM_RDATA  <= {DW{1'b0}};
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= {AW{1'b0}};
      MEM_WDATA <= {DW{1'b0}};
      BUSY      <= 1'b0;
    end else begin
      IF_GNT    <= 1'b0;
      IF_RVALID <= 1'b0;
      DM_GNT    <= 1'b0;
      DM_RVALID <= 1'b0;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_any) begin
            r_state  <= ST_ISSUE;
            r_sel    <= w_sel;
            r_we     <= (w_sel == SEL_DM) && DM_WE;
            IF_GNT   <= (w_sel == SEL_IF);
            DM_GNT   <= (w_sel == SEL_DM);
            MEM_EN   <= 1'b1;
            MEM_WE   <= (w_sel == SEL_DM) && DM_WE;
            MEM_ADDR <= (w_sel == SEL_DM) ? DM_ADDR : IF_ADDR;
            // Write data bus only moves for writes so it holds its last value otherwise.
            if ((w_sel == SEL_DM) && DM_WE) begin
              MEM_WDATA <= DM_WDATA;
            end else begin
              MEM_WDATA <= MEM_WDATA;
            end
            BUSY <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            BUSY    <= 1'b0;
          end
        end
        ST_ISSUE: begin
          BUSY <= 1'b1;
          if (r_we) begin
            r_state   <= ST_DONE;
            DM_RVALID <= 1'b1;
          end else if (MEM_LAT == 1) begin
            r_state <= ST_DONE;
            if (r_sel == SEL_DM) begin
              DM_RDATA  <= MEM_RDATA;
              DM_RVALID <= 1'b1;
            end else begin
              IF_RDATA  <= MEM_RDATA;
              IF_RVALID <= 1'b1;
            end
          end else begin
            r_state   <= ST_WAIT;
            r_lat_cnt <= LAT_W'(MEM_LAT - 2);
          end
        end
        ST_WAIT: begin
          BUSY <= 1'b1;
          if (r_lat_cnt == {LAT_W{1'b0}}) begin
            r_state <= ST_DONE;
            if (r_sel == SEL_DM) begin
              DM_RDATA  <= MEM_RDATA;
              DM_RVALID <= 1'b1;
            end else begin
              IF_RDATA  <= MEM_RDATA;
              IF_RVALID <= 1'b1;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: transaction-level timeline model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arb;

  localparam int AW         = 8;
  localparam int DW         = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic          CLK      = 1'b0;
  logic          RST_F    = 1'b0;
  logic          IF_REQ   = 1'b0;
  logic [AW-1:0] IF_ADDR  = '0;
  logic          DM_REQ   = 1'b0;
  logic          DM_WE    = 1'b0;
  logic [AW-1:0] DM_ADDR  = '0;
  logic [DW-1:0] DM_WDATA = '0;
  logic          IF_GNT, IF_RVALID, DM_GNT, DM_RVALID, MEM_EN, MEM_WE, BUSY;
  logic [DW-1:0] IF_RDATA, DM_RDATA, MEM_WDATA, MEM_RDATA;
  logic [AW-1:0] MEM_ADDR;

  mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST_F(RST_F),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_GNT(DM_GNT), .DM_RVALID(DM_RVALID), .DM_RDATA(DM_RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h5A00_0000 | 32'(i * 3);
  endfunction

  // Memory macro: 1-edge registered read, so data is present at the MEM_LAT-th edge.
  logic [DW-1:0] mem_arr [0:255];
  logic [DW-1:0] mem_q = '0;
  assign MEM_RDATA = mem_q;
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    forever begin
      @(posedge CLK);
      if (MEM_EN) begin
        if (MEM_WE) mem_arr[MEM_ADDR] = MEM_WDATA;
        else        mem_q = mem_arr[MEM_ADDR];
      end
    end
  end

  // Reference model: absolute-time schedule of the current transaction.
  logic [DW-1:0] ref_mem [0:255];
  int cyc = 0, next_dec = 0, starve = 0, t_start = -10, t_lat = 0;
  bit t_valid = 0, t_dm = 0, t_we = 0;
  logic [DW-1:0] t_rdata = '0, m_if_rdata = '0, m_dm_rdata = '0, m_wdata = '0;
  logic [AW-1:0] m_addr = '0;

  initial begin
    bit sel_dm;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    forever begin
      @(posedge CLK or negedge RST_F);
      if (!RST_F) begin
        t_valid = 0; starve = 0; next_dec = 0;
        m_if_rdata = '0; m_dm_rdata = '0; m_wdata = '0; m_addr = '0;
      end else begin
        cyc++;
        if (t_valid && !t_we && cyc == t_start + t_lat) begin
          if (t_dm) m_dm_rdata = t_rdata;
          else      m_if_rdata = t_rdata;
        end
        if (cyc >= next_dec) begin
          if (IF_REQ || DM_REQ) begin
            sel_dm = DM_REQ && !(IF_REQ && starve == STARVE_MAX);
            if (sel_dm && IF_REQ) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
            else if (!sel_dm)     starve = 0;
            t_valid = 1; t_start = cyc; t_dm = sel_dm; t_we = sel_dm && DM_WE;
            m_addr  = sel_dm ? DM_ADDR : IF_ADDR;
            t_lat   = t_we ? 1 : MEM_LAT;
            if (t_we) begin
              m_wdata = DM_WDATA;
              ref_mem[m_addr] = DM_WDATA;
            end
            t_rdata  = ref_mem[m_addr];
            next_dec = cyc + t_lat + 1;
          end else begin
            next_dec = cyc + 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    bit is_gnt, is_done;
    forever begin
      @(negedge CLK);
      is_gnt  = t_valid && (cyc == t_start);
      is_done = t_valid && (cyc == t_start + t_lat);
      chk("IF_GNT",    IF_GNT,    is_gnt && !t_dm);
      chk("DM_GNT",    DM_GNT,    is_gnt && t_dm);
      chk("MEM_EN",    MEM_EN,    is_gnt);
      chk("MEM_WE",    MEM_WE,    is_gnt && t_we);
      chk("IF_RVALID", IF_RVALID, is_done && !t_dm);
      chk("DM_RVALID", DM_RVALID, is_done && t_dm);
      chk("BUSY",      BUSY,      t_valid && cyc >= t_start && cyc <= t_start + t_lat);
      chk("MEM_ADDR",  MEM_ADDR,  m_addr);
      chk("MEM_WDATA", MEM_WDATA, m_wdata);
      chk("IF_RDATA",  IF_RDATA,  m_if_rdata);
      chk("DM_RDATA",  DM_RDATA,  m_dm_rdata);
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge CLK);
      if (!BUSY) ok = 1;
    end
    if (!ok) chk("wait_idle_timeout", BUSY, 1'b0);
  endtask

  initial begin
    bit got, gi, gd;
    int ng;
    logic [4:0] gv;

    // 1: reset with both requests high, then release.
    IF_REQ = 1'b1; IF_ADDR = 8'h06; DM_REQ = 1'b1; DM_WE = 1'b0; DM_ADDR = 8'h05;
    repeat (3) @(negedge CLK);
    chk("T1_rst_busy", BUSY, 1'b0);
    chk("T1_rst_gnt", {IF_GNT, DM_GNT, MEM_EN, MEM_WE}, 4'b0000);
    chk("T1_rst_rdata", IF_RDATA | DM_RDATA, 32'h0);
    RST_F = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("T1_first_dm_gnt", {IF_GNT, DM_GNT}, 2'b01);
    @(posedge CLK); #1 DM_REQ = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      if (IF_GNT) got = 1;
    end
    chk("T1_if_gnt_after", got, 1'b1);
    @(posedge CLK); #1 IF_REQ = 1'b0;
    wait_idle();
    chk("T1_dm_rdata", DM_RDATA, 32'h5A00_000F);

    // 2: fetch read of 0x10.
    mem_arr[8'h10] = 32'hDEAD_BEEF; ref_mem[8'h10] = 32'hDEAD_BEEF;
    @(posedge CLK); #1 IF_REQ = 1'b1; IF_ADDR = 8'h10;
    @(posedge CLK); @(negedge CLK);
    chk("T2_c1_gnt_en", {IF_GNT, MEM_EN, MEM_WE}, 3'b110);
    chk("T2_c1_addr", MEM_ADDR, 8'h10);
    @(posedge CLK); #1 IF_REQ = 1'b0;
    @(negedge CLK);
    chk("T2_c2_wait", {BUSY, IF_RVALID}, 2'b10);
    @(negedge CLK);
    chk("T2_c3_rvalid", IF_RVALID, 1'b1);
    chk("T2_c3_rdata", IF_RDATA, 32'hDEAD_BEEF);
    wait_idle();

    // 3: data write 0x20 <- 0x1234.
    @(posedge CLK); #1 DM_REQ = 1'b1; DM_WE = 1'b1; DM_ADDR = 8'h20; DM_WDATA = 32'h0000_1234;
    @(posedge CLK); @(negedge CLK);
    chk("T3_c1_ctl", {DM_GNT, MEM_EN, MEM_WE}, 3'b111);
    chk("T3_c1_addr", MEM_ADDR, 8'h20);
    chk("T3_c1_wdata", MEM_WDATA, 32'h0000_1234);
    @(posedge CLK); #1 DM_REQ = 1'b0; DM_WE = 1'b0;
    @(negedge CLK);
    chk("T3_c2_rvalid", DM_RVALID, 1'b1);
    chk("T3_c2_rdata_kept", DM_RDATA, 32'h5A00_000F);
    wait_idle();

    // 4: simultaneous fetch and data read; data first, fetch with no gap.
    @(posedge CLK); #1 IF_REQ = 1'b1; IF_ADDR = 8'h31; DM_REQ = 1'b1; DM_ADDR = 8'h30;
    @(posedge CLK); @(negedge CLK);
    chk("T4_c1_dm_first", {IF_GNT, DM_GNT}, 2'b01);
    @(posedge CLK); #1 DM_REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("T4_c3_dm_rvalid", DM_RVALID, 1'b1);
    chk("T4_c3_dm_rdata", DM_RDATA, 32'h5A00_0090);
    @(negedge CLK);
    chk("T4_c4_if_gnt", IF_GNT, 1'b1);
    @(posedge CLK); #1 IF_REQ = 1'b0;
    wait_idle();
    chk("T4_if_rdata", IF_RDATA, 32'h5A00_0093);

    // 5: starvation guard with both requests held.
    @(posedge CLK); #1 IF_REQ = 1'b1; IF_ADDR = 8'h41; DM_REQ = 1'b1; DM_ADDR = 8'h40;
    ng = 0; gv = '0;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      @(negedge CLK);
      gi = IF_GNT; gd = DM_GNT;
      if (gi || gd) begin
        gv[ng] = gd;
        ng++;
        @(posedge CLK); #1;
        if (gi) IF_REQ = 1'b0;
        if (ng == 5) DM_REQ = 1'b0;
      end
    end
    chk("T5_grant_count", ng, 5);
    chk("T5_grant_order", gv, 5'b10111);
    wait_idle();

    // 6: reset during fetch WAIT drops the transaction.
    @(posedge CLK); #1 IF_REQ = 1'b1; IF_ADDR = 8'h10;
    @(posedge CLK); @(negedge CLK);
    chk("T6_c1_gnt", IF_GNT, 1'b1);
    @(posedge CLK); #1 IF_REQ = 1'b0;
    @(negedge CLK);
    chk("T6_c2_busy", BUSY, 1'b1);
    #2 RST_F = 1'b0;
    #1;
    chk("T6_async_busy", BUSY, 1'b0);
    chk("T6_async_rdata", IF_RDATA, 32'h0);
    @(negedge CLK);
    chk("T6_no_rvalid", IF_RVALID, 1'b0);
    RST_F = 1'b1;
    @(posedge CLK); #1 IF_REQ = 1'b1; IF_ADDR = 8'h44;
    @(posedge CLK); @(negedge CLK);
    chk("T6_new_gnt", IF_GNT, 1'b1);
    @(posedge CLK); #1 IF_REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("T6_new_rvalid", IF_RVALID, 1'b1);
    chk("T6_new_rdata", IF_RDATA, 32'h5A00_00CC);
    wait_idle();

    // Random traffic obeying the requester contract.
    for (int c = 0; c < 2500; c++) begin
      @(negedge CLK);
      gi = IF_GNT; gd = DM_GNT;
      @(posedge CLK); #1;
      if (!IF_REQ || gi) begin
        if ($urandom_range(0, 99) < 50) begin
          IF_REQ = 1'b1; IF_ADDR = AW'($urandom);
        end else begin
          IF_REQ = 1'b0;
        end
      end
      if (!DM_REQ || gd) begin
        if ($urandom_range(0, 99) < 70) begin
          DM_REQ = 1'b1; DM_WE = 1'($urandom_range(0, 1));
          DM_ADDR = AW'($urandom); DM_WDATA = $urandom;
        end else begin
          DM_REQ = 1'b0;
        end
      end
    end
    IF_REQ = 1'b0; DM_REQ = 1'b0;
    wait_idle();
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
